mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit (MULTU/MULT/DIVU/DIV) with HI/LO result
// registers, fixed 34-edge latency and divide-by-zero flagging.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;        // operand signs differ (signed ops only)
  logic             sign_a_q, sign_a_d;  // dividend sign, for the remainder
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] m_q, m_d;            // multiplicand or divisor magnitude
  logic [WIDTH-1:0] p_hi_q, p_hi_d;      // partial product high / running remainder
  logic [WIDTH-1:0] p_lo_q, p_lo_d;      // multiplier bits / quotient bits
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept;
  logic             is_signed;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   alu_a, alu_b, mul_sum;
  logic [WIDTH+1:0] alu_res;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign accept    = (state_q == IDLE) && start;
  assign is_signed = op[0];
  assign sa        = is_signed & A[WIDTH-1];
  assign sb        = is_signed & B[WIDTH-1];
  assign abs_a     = sa ? (~A + 1'b1) : A;
  assign abs_b     = sb ? (~B + 1'b1) : B;

  // Shared 33-bit adder/subtractor; bit WIDTH+1 is the carry-out (borrow on divide).
  assign alu_a   = is_div_q ? {p_hi_q, p_lo_q[WIDTH-1]} : {1'b0, p_hi_q};
  assign alu_b   = {1'b0, m_q};
  assign alu_res = is_div_q ? ({1'b0, alu_a} - {1'b0, alu_b})
                            : ({1'b0, alu_a} + {1'b0, alu_b});
  assign mul_sum = p_lo_q[0] ? alu_res[WIDTH:0] : {1'b0, p_hi_q};

  assign prod     = {p_hi_q, p_lo_q};
  assign prod_neg = ~prod + 1'b1;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    bzero_d  = bzero_q;
    a_raw_d  = a_raw_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = sa ^ sb;
          sign_a_d = sa;
          bzero_d  = (B == '0);
          a_raw_d  = A;
          busy_d   = 1'b1;
          dz_d     = 1'b0;
          if (op[1]) begin
            m_d    = abs_b;
            p_hi_d = '0;
            p_lo_d = abs_a;
          end else begin
            m_d    = abs_a;
            p_hi_d = '0;
            p_lo_d = abs_b;
          end
        end
      end

      CALC: begin
        // Counts 0..WIDTH-1 iterate; the final slot aligns completion to edge k+34.
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            if (!alu_res[WIDTH+1]) begin
              p_hi_d = alu_res[WIDTH-1:0];
              p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              p_hi_d = alu_a[WIDTH-1:0];
              p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            p_hi_d = mul_sum[WIDTH:1];
            p_lo_d = {mul_sum[0], p_lo_q[WIDTH-1:1]};
          end
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q && bzero_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else if (is_div_q) begin
          hi_d = sign_a_q ? (~p_hi_q + 1'b1) : p_hi_q;
          lo_d = neg_q    ? (~p_lo_q + 1'b1) : p_lo_q;
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      bzero_q  <= 1'b0;
      a_raw_q  <= '0;
      m_q      <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      bzero_q  <= bzero_d;
      a_raw_q  <= a_raw_d;
      m_q      <= m_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: products, quotients, divide by zero,
// latency, ignored/back-to-back starts and mid-operation reset.
module tb_mul_div_unit;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, DivZero;
  logic [31:0] HI, LO;

  int n_cmp;
  int n_bad;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .HI     (HI),
    .LO     (LO),
    .DivZero(DivZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives a start for one cycle, then counts edges (sampled #1 after each) until done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic expect_result(input string tag, input int lat, input logic [31:0] hi,
                               input logic [31:0] lo, input logic dz);
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " HI"}, 64'(HI), 64'(hi));
    check({tag, " LO"}, 64'(LO), 64'(lo));
    check({tag, " DivZero"}, 64'(DivZero), 64'(dz));
    check({tag, " busy@done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen_done;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0;
    #23;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    check("reset DivZero", 64'(DivZero), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    expect_result("multu max", lat, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(posedge clk); #1;
    check("done one cycle", 64'(done), 64'd0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat);
    expect_result("mult -3*7", lat, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    expect_result("mult min*min", lat, 32'h4000_0000, 32'h0000_0000, 1'b0);

    run_op(OP_MULTU, 32'h1234_5678, 32'h10, lat);
    expect_result("multu shift", lat, 32'h0000_0001, 32'h2345_6780, 1'b0);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    expect_result("div -7/2", lat, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat);
    expect_result("div 7/-2", lat, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    expect_result("div min/-1", lat, 32'h0000_0000, 32'h8000_0000, 1'b0);

    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    expect_result("divu 100/7", lat, 32'd2, 32'd14, 1'b0);

    run_op(OP_DIVU, 32'd100, 32'd0, lat);
    expect_result("divu by zero", lat, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("DivZero held", 64'(DivZero), 64'd1);

    run_op(OP_MULTU, 32'd2, 32'd3, lat);
    expect_result("multu 2*3", lat, 32'd0, 32'd6, 1'b0);

    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, lat);
    expect_result("div -5 by zero", lat, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

    // Second start at CALC cycle 5 must be ignored; HI/LO hold the old result while busy.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; A = 32'd1000; B = 32'd1000;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (5) begin
      @(posedge clk); #1; lat++;
    end
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; A = 32'd77; B = 32'd5;
    @(posedge clk); #1; lat++;
    start = 1'b0;
    check("hold HI busy", 64'(HI), 64'hFFFF_FFFB);
    check("hold LO busy", 64'(LO), 64'hFFFF_FFFF);
    check("DivZero cleared on start", 64'(DivZero), 64'd0);
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    expect_result("ignored start", lat, 32'd0, 32'd1_000_000, 1'b0);

    // Start driven during the done cycle is accepted with no idle gap.
    check("done before b2b", 64'(done), 64'd1);
    run_op(OP_MULTU, 32'd9, 32'd11, lat);
    expect_result("back-to-back", lat, 32'd0, 32'd99, 1'b0);

    // Reset asserted mid-CALC aborts the operation asynchronously.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort HI", 64'(HI), 64'd0);
    check("abort LO", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("no done after abort", 64'(seen_done), 64'd0);
    check("idle after abort", 64'(busy), 64'd0);

    run_op(OP_MULTU, 32'd5, 32'd5, lat);
    expect_result("multu 5*5", lat, 32'd0, 32'd25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
